// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the packet-locked round-robin arbiter.
// The state encoding is one bit: IDLE while arbitrating, BUSY while a packet holds the grant.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEF_BITS_ENABLES = 2;
  localparam int DEF_BUS_SIZE     = 8;

endpackage

// File: rtl/mux.sv
// Selects one BUS_SIZE slice of a flattened bus by index.
// No latency; no backpressure.
module mux #(
  parameter int BITS_ENABLES = 2,
  parameter int BUS_SIZE     = 8,
  localparam int NUM_BLOCKS  = 2**BITS_ENABLES
) (
  input  logic [BITS_ENABLES-1:0]        i_en,
  input  logic [NUM_BLOCKS*BUS_SIZE-1:0] i_data,
  output logic [BUS_SIZE-1:0]            o_data
);

  assign o_data = i_data[i_en*BUS_SIZE +: BUS_SIZE];

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search (purely combinational): first set request above ptr, wrapping.
// No latency; no backpressure.
module rr_pick #(
  parameter int W = 2,
  localparam int N = 2**W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  always_comb begin
    logic [W-1:0] idx;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // Offset N truncates to 0 and revisits ptr itself as lowest priority.
    for (int k = 1; k <= N; k++) begin
      idx = ptr + W'(k);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 packet arbiter with a one-entry registered output; grant held until last beat.
// Grant one edge after request, beat out one edge after accept; requester ready follows !o_valid | i_ready.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int BITS_ENABLES = DEF_BITS_ENABLES,
  parameter int BUS_SIZE     = DEF_BUS_SIZE,
  localparam int NUM_BLOCKS  = 2**BITS_ENABLES
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic [NUM_BLOCKS-1:0]          i_req_valid,
  input  logic [NUM_BLOCKS-1:0]          i_req_last,
  input  logic [NUM_BLOCKS*BUS_SIZE-1:0] i_req_data,
  output logic [NUM_BLOCKS-1:0]          o_req_ready,
  output logic [BITS_ENABLES-1:0]        o_sel,
  output logic                           o_valid,
  output logic [BUS_SIZE-1:0]            o_data,
  output logic                           o_last,
  output logic [BITS_ENABLES-1:0]        o_src,
  input  logic                           i_ready,
  output logic                           o_busy
);

  state_t                  state;
  logic [BITS_ENABLES-1:0] rr_ptr;
  logic [BITS_ENABLES-1:0] pick_idx;
  logic                    pick_any;
  logic [BUS_SIZE-1:0]     mux_dat;
  logic                    out_free;
  logic                    accept;

  rr_pick #(.W(BITS_ENABLES)) u_pick (
    .req    (i_req_valid),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  mux #(.BITS_ENABLES(BITS_ENABLES), .BUS_SIZE(BUS_SIZE)) u_mux (
    .i_en   (o_sel),
    .i_data (i_req_data),
    .o_data (mux_dat)
  );

  assign out_free = !o_valid || i_ready;
  assign accept   = (state == ST_BUSY) && i_req_valid[o_sel] && out_free;
  assign o_busy   = (state == ST_BUSY);

  always_comb begin
    o_req_ready = '0;
    if (state == ST_BUSY) o_req_ready[o_sel] = out_free;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= BITS_ENABLES'(NUM_BLOCKS - 1);
      o_sel   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_src   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The output stage keeps draining while the next winner is chosen.
          if (i_ready) o_valid <= 1'b0;
          if (pick_any) begin
            o_sel <= pick_idx;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            o_valid <= 1'b1;
            o_data  <= mux_dat;
            o_last  <= i_req_last[o_sel];
            o_src   <= o_sel;
            if (i_req_last[o_sel]) begin
              rr_ptr <= o_sel;
              state  <= ST_IDLE;
            end
          end else if (i_ready) begin
            o_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
